mult_sched: RTL
===============

Name: mult_sched

Overview:
Controller and arbiter for the shared 8-bit signed shift-add multiplier datapath (accumulator A, multiplier register B, multiplicand S). It accepts multiply jobs from NUM_REQ independent requesters and selects one with round-robin arbitration. It then sequences the datapath through load, WIDTH add/sub-then-shift iterations and result capture. The result is returned over a 4-phase req/done handshake. It sits between the requester logic and the multiplier datapath, which then needs no control unit of its own.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
WIDTH, 8, operand width; iteration count; product is 2*WIDTH bits

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester job request; held until matching done seen
op_a  in  NUM_REQ*WIDTH  per-requester multiplicand (slice i = requester i)
op_b  in  NUM_REQ*WIDTH  per-requester multiplier
gnt  out  NUM_REQ  one-hot, requester currently owning datapath
done  out  NUM_REQ  one-hot, result valid for granted requester
result  out  2*WIDTH  signed product, registered, shared by all requesters
busy  out  1  high in any state other than IDLE
dp_s  out  WIDTH  multiplicand to datapath (latched op_a of winner)
dp_b  out  WIDTH  multiplier load value (latched op_b of winner)
dp_ld  out  1  load B from dp_b and S from dp_s
dp_clearA  out  1  clear accumulator A and sign-extend bit X
dp_add  out  1  A <= A + S this cycle
dp_sub  out  1  A <= A - S this cycle
dp_shift  out  1  arithmetic shift right of X:A:B
dp_m  in  1  current LSB of B
dp_product  in  2*WIDTH  A:B concatenation from datapath

Behaviour:
- Reset (async): state IDLE; gnt, done, busy, all dp_* controls 0; dp_s, dp_b, result 0; iteration counter 0; RR pointer points at requester 0 (highest priority).
- States: IDLE, LOAD, ADD, SHIFT, CAPTURE, DONE. Moore decode; dp_* controls depend only on state, counter and dp_m.
- IDLE: if any req bit is high, the RR arbiter picks the first requester at or after the pointer. It latches op_a/op_b slices into dp_s/dp_b, sets gnt one-hot, and goes to LOAD. Otherwise stays.
- LOAD: dp_ld=1, dp_clearA=1; counter <= 0; -> ADD.
- ADD: if dp_m=0, no op. If dp_m=1 and counter==WIDTH-1, dp_sub=1 (sign bit of multiplier). Otherwise if dp_m=1, dp_add=1. -> SHIFT.
- SHIFT: dp_shift=1; counter <= counter+1. If counter==WIDTH-1 go to CAPTURE, else go to ADD. The counter is $clog2(WIDTH)+1 bits wide and never wraps within a job.
- CAPTURE: result <= dp_product -> DONE.
- DONE: done[g]=1 while req[g]=1. When req[g]=0, clear gnt and done, move the RR pointer to g+1 (mod NUM_REQ), and go to IDLE.
- Latency: req high in IDLE at cycle 0 -> done high from cycle 2*WIDTH+3 (19 for WIDTH=8). Back-to-back minimum: one IDLE cycle between jobs.
- result holds its value until the next CAPTURE.
- Simultaneous requests: the pointer decides; the loser waits with req held. No starvation: each requester waits at most NUM_REQ-1 jobs.
- Operand changes after grant are ignored (already latched).
- req[g] dropped before DONE: the job runs to completion, result is still captured, and DONE exits immediately because req[g] is already 0. In that case done pulses 0 cycles.
- req on a non-granted requester during a job: ignored until IDLE.
- dp_add and dp_sub are never both 1. At most one of dp_ld/dp_add/dp_sub/dp_shift is active except in LOAD, where dp_ld and dp_clearA are both 1.
- Reset mid-operation: immediate return to reset values. The datapath is not touched further, and the interrupted job is not resumed.

Decomposition:
- Shared package mult_pkg: sched_state_t enum (IDLE, LOAD, ADD, SHIFT, CAPTURE, DONE), DEFAULT_WIDTH=8, product width helper constant.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin picker. Inputs are req and pointer; the output is a one-hot grant plus a valid bit. Purely combinational, with the pointer register living in mult_sched.

Test Plan:
- req[0], op_a=8'h07, op_b=8'h03 -> gnt=2'b01, done[0] at cycle 19, result=16'h0015; drop req -> IDLE next cycle, busy=0.
- Signed: op_a=8'hFE (-2), op_b=8'h05 -> 16'hFFF6. Then op_a=8'h80, op_b=8'h80 -> 16'h4000. Then op_a=8'h80, op_b=8'h01 -> 16'hFF80 (checks the sub on the last iteration).
- req=2'b11 right after reset, op0 3*4, op1 5*6 -> requester 0 served first (result 16'h000C). Requester 1 is served next without re-arbitration loss (result 16'h001E), and gnt is never 2'b11.
- Fairness: both requesters re-raise req immediately after each done for 4 jobs -> grants alternate 0,1,0,1.
- Reset asserted at cycle 10 of a job -> all outputs 0 asynchronously. A new req[1] with 2*2 completes correctly with result 16'h0004.
- Operand change after grant and early req drop -> result reflects the latched operands, and the FSM returns to IDLE without hanging.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier scheduler.
// Holds the FSM state encoding and the operand/product width defaults.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ADD     = 3'd2,
    SHIFT   = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } sched_state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  localparam int DEFAULT_PROD_W = prod_width(DEFAULT_WIDTH);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first requester at or after ptr; combinational, no state.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               vld
);

  always_comb begin
    int idx;
    idx = 0;
    gnt = '0;
    vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Arbitrates multiply jobs round-robin and sequences the shared signed shift-add datapath.
// Result returned over a 4-phase req/done handshake; done appears 2*WIDTH+3 cycles after grant.
module mult_sched
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] op_a,
  input  logic [NUM_REQ*WIDTH-1:0] op_b,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [2*WIDTH-1:0]       result,
  output logic                     busy,
  output logic [WIDTH-1:0]         dp_s,
  output logic [WIDTH-1:0]         dp_b,
  output logic                     dp_ld,
  output logic                     dp_clearA,
  output logic                     dp_add,
  output logic                     dp_sub,
  output logic                     dp_shift,
  input  logic                     dp_m,
  input  logic [2*WIDTH-1:0]       dp_product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t       state;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_vld;
  logic [WIDTH-1:0]   win_s;
  logic [WIDTH-1:0]   win_b;
  logic               last_iter;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .vld (arb_vld)
  );

  always_comb begin
    win_s = '0;
    win_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        win_s = op_a[i*WIDTH +: WIDTH];
        win_b = op_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
    ptr_nxt = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // The multiplier's MSB carries negative weight, so the final iteration subtracts.
  assign dp_ld     = (state == LOAD);
  assign dp_clearA = (state == LOAD);
  assign dp_add    = (state == ADD) && dp_m && !last_iter;
  assign dp_sub    = (state == ADD) && dp_m && last_iter;
  assign dp_shift  = (state == SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      ptr    <= '0;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      result <= '0;
      dp_s   <= '0;
      dp_b   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_vld) begin
            gnt   <= arb_gnt;
            dp_s  <= win_s;
            dp_b  <= win_b;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= ADD;
        end
        ADD: state <= SHIFT;
        SHIFT: begin
          cnt   <= cnt + 1'b1;
          state <= last_iter ? CAPTURE : ADD;
        end
        CAPTURE: begin
          result <= dp_product;
          done   <= gnt & req;
          state  <= DONE;
        end
        DONE: begin
          // Owner already dropped req (possibly before capture): release immediately.
          if ((gnt & req) == '0) begin
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            ptr   <= ptr_nxt;
            state <= IDLE;
          end else begin
            done <= gnt & req;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
